// File: rtl/hdmi_text_pkg.sv
// hdmi_text_pkg: shared text-mode geometry, cell/colour types and palette lookup.
package hdmi_text_pkg;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;
  localparam int WORDS_PER_ROW = 40;
  typedef struct packed {
    logic       inv;
    logic [6:0] code;
    logic [3:0] fg;
    logic [3:0] bg;
  } text_cell_t;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;
  // Two 12-bit colours per palette word: even index in [11:0], odd in [27:16].
  function automatic rgb444_t pal_colour(input logic [7:0][31:0] pal, input logic [3:0] idx);
    return idx[0] ? pal[idx[3:1]][27:16] : pal[idx[3:1]][11:0];
  endfunction
endpackage

// File: rtl/hdmi_text_delay_line.sv
// hdmi_text_delay_line: WIDTH-bit shift register of DEPTH stages, sync active-low reset.
module hdmi_text_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;
  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) pipe_q <= '0;
    else pipe_q <= pipe_d;
  end
  assign dout = pipe_q[DEPTH-1];
endmodule

// File: rtl/hdmi_text_pixel_pipe.sv
// hdmi_text_pixel_pipe: 80x30 text-mode pixel pipeline, latency 3+VRAM_LAT+FONT_LAT.
// Define HDMI_TEXT_CURSOR_EN to add the blinking underline cursor driven by ctrl_reg.
module hdmi_text_pixel_pipe
  import hdmi_text_pkg::*;
#(
  parameter int VRAM_LAT = 1,
  parameter int FONT_LAT = 1
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             vde_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  output logic [10:0]      vram_addr,
  input  logic [31:0]      vram_data,
  output logic [10:0]      font_rom_address,
  input  logic [7:0]       font_data,
  input  logic [7:0][31:0] palette,
  input  logic [31:0]      ctrl_reg,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue,
  output logic             vde_out,
  output logic             hsync_out,
  output logic             vsync_out
);
  localparam int S1_DLY = 1 + VRAM_LAT;
  localparam int S2_DLY = 2 + VRAM_LAT + FONT_LAT;
  logic [10:0] vram_addr_q, vram_addr_d, font_rom_address_q, font_rom_address_d;
  rgb444_t     rgb_q, rgb_d;
  logic [2:0]  sync_q, sync_d;
  logic        half_s1, vde_s2, hs_s2, vs_s2, cur_s0, cur_s2, on;
  logic [3:0]  gy_s1;
  logic [2:0]  gx_s2;
  logic [8:0]  attr_s2;
  text_cell_t  cell_s1;
  logic        unused;
  hdmi_text_delay_line #(.WIDTH(5), .DEPTH(S1_DLY)) u_s1 (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN),
    .din({DrawX[3], DrawY[3:0]}), .dout({half_s1, gy_s1})
  );
  hdmi_text_delay_line #(.WIDTH(7), .DEPTH(S2_DLY)) u_s2 (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN),
    .din({vde_in, hsync_in, vsync_in, DrawX[2:0], cur_s0}),
    .dout({vde_s2, hs_s2, vs_s2, gx_s2, cur_s2})
  );
  // Attributes leave S1 combinationally and must wait out the font ROM latency.
  hdmi_text_delay_line #(.WIDTH(9), .DEPTH(FONT_LAT + 1)) u_attr (
    .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN),
    .din({cell_s1.inv, cell_s1.fg, cell_s1.bg}), .dout(attr_s2)
  );
  always_comb begin
    vram_addr_d = 11'(32'(DrawY[8:4]) * WORDS_PER_ROW + 32'(DrawX[9:4]));
    cell_s1 = half_s1 ? vram_data[31:16] : vram_data[15:0];
    font_rom_address_d = {cell_s1.code, gy_s1};
    on = (font_data[3'd7 - gx_s2] ^ attr_s2[8]) | cur_s2;
    rgb_d = !vde_s2 ? '0 : on ? pal_colour(palette, attr_s2[7:4]) : pal_colour(palette, attr_s2[3:0]);
    sync_d = {vde_s2, hs_s2, vs_s2};
  end
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      vram_addr_q        <= '0;
      font_rom_address_q <= '0;
      rgb_q              <= '0;
      sync_q             <= '0;
    end else begin
      vram_addr_q        <= vram_addr_d;
      font_rom_address_q <= font_rom_address_d;
      rgb_q              <= rgb_d;
      sync_q             <= sync_d;
    end
  end
`ifdef HDMI_TEXT_CURSOR_EN
  logic [4:0] blink_q, blink_d;
  logic       vs_prev_q, vs_prev_d;
  always_comb begin
    vs_prev_d = vsync_in;
    blink_d = blink_q + 5'(vsync_in & ~vs_prev_q);
    cur_s0 = ctrl_reg[12] & blink_q[4] & (DrawY[3:1] == 3'b111) &
             (12'(32'(DrawY[8:4]) * COLS + 32'(DrawX[9:3])) == ctrl_reg[11:0]);
  end
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      blink_q   <= '0;
      vs_prev_q <= 1'b0;
    end else begin
      blink_q   <= blink_d;
      vs_prev_q <= vs_prev_d;
    end
  end
  assign unused = ^{ctrl_reg[31:13], DrawY[9], palette};
`else
  assign cur_s0 = 1'b0;
  assign unused = ^{ctrl_reg, DrawY[9], palette};
`endif
  assign vram_addr        = vram_addr_q;
  assign font_rom_address = font_rom_address_q;
  assign {red, green, blue} = rgb_q;
  assign {vde_out, hsync_out, vsync_out} = sync_q;
endmodule
